// File: rtl/seven_seg_if.sv
// Frame-in / pins-out bundle for the seven-segment scan driver.
// master = frame producer (counter/status logic), slave = the scan driver.
interface seven_seg_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    hex_mode;
    logic                    lz_suppress;
    logic                    load;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   digit;
    logic                    frame_done;

    modport master (
        output digits_in, dp_in, blank_in, hex_mode, lz_suppress, load,
        input  seg, digit, frame_done
    );

    modport slave (
        input  digits_in, dp_in, blank_in, hex_mode, lz_suppress, load,
        output seg, digit, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: one digit lit at a time,
// dark gap between digits, leading-zero suppression, tear-free frame swaps.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    seven_seg_if.slave disp
);

    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MAX_CNT = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int PW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam bit HAS_GAP = (BLANK_CYCLES > 0);

    localparam logic [PW-1:0] SHOW_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = HAS_GAP ? PW'(BLANK_CYCLES - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] codes;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
        logic                    hex;
        logic                    lz;
    } frame_t;

    // Power-up frame keeps every digit dark until the first load arrives.
    localparam frame_t FRAME_DARK = '{codes: '0, dp: '0, blank: '1, hex: 1'b0, lz: 1'b0};

    state_t                r_state, w_state_next;
    logic [IW-1:0]         r_idx, w_idx_next, w_idx_inc;
    logic [PW-1:0]         r_presc, w_presc_next;
    logic                  w_frame_end;

    frame_t                r_act, r_pend, w_in_frame;
    logic                  r_pend_valid;

    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_digit;
    logic                  r_frame_done;

    logic [7:0]            w_seg_tbl [2**IW];
    logic [7:0]            w_seg_sel;
    logic [NUM_DIGITS-1:0] w_digit_on;
    logic [NUM_DIGITS:0]   w_upper_zero;
    logic [NUM_DIGITS-1:0] w_dark;

    function automatic logic [6:0] glyph(input logic [3:0] code, input logic hex);
        logic [6:0] g;
        case (code)
            4'h0: g = 7'h01;
            4'h1: g = 7'h4F;
            4'h2: g = 7'h12;
            4'h3: g = 7'h06;
            4'h4: g = 7'h4C;
            4'h5: g = 7'h24;
            4'h6: g = 7'h20;
            4'h7: g = 7'h0F;
            4'h8: g = 7'h00;
            4'h9: g = 7'h04;
            4'hA: g = 7'h08;
            4'hB: g = 7'h60;
            4'hC: g = 7'h31;
            4'hD: g = 7'h42;
            4'hE: g = 7'h30;
            default: g = 7'h38;
        endcase
        if (!hex && (code > 4'd9)) begin
            g = 7'h7E;
        end
        return g;
    endfunction

    // The frame ends on the last cycle of the final digit's slot (its gap if there is one).
    function automatic logic is_frame_end(input state_t st, input logic [IW-1:0] idx,
                                          input logic [PW-1:0] pc);
        if (HAS_GAP) begin
            return (st == ST_BLANK) && (idx == IDX_LAST) && (pc == BLANK_LAST);
        end
        return (st == ST_SHOW) && (idx == IDX_LAST) && (pc == SHOW_LAST);
    endfunction

    assign w_idx_inc   = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    assign w_frame_end = is_frame_end(r_state, r_idx, r_presc);
    assign w_in_frame  = {disp.digits_in, disp.dp_in, disp.blank_in, disp.hex_mode, disp.lz_suppress};

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_presc_next = r_presc + PW'(1);
        unique case (r_state)
            ST_SHOW: begin
                if (r_presc == SHOW_LAST) begin
                    w_presc_next = '0;
                    if (HAS_GAP) begin
                        w_state_next = ST_BLANK;
                    end else begin
                        w_idx_next = w_idx_inc;
                    end
                end
            end
            ST_BLANK: begin
                if (r_presc == BLANK_LAST) begin
                    w_presc_next = '0;
                    w_state_next = ST_SHOW;
                    w_idx_next   = w_idx_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SHOW;
            r_idx   <= '0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_presc <= w_presc_next;
        end
    end

    // A load landing on the frame-end cycle goes straight to the active frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act        <= FRAME_DARK;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
        end else if (disp.load) begin
            if (w_frame_end) begin
                r_act        <= w_in_frame;
                r_pend_valid <= 1'b0;
            end else begin
                r_pend       <= w_in_frame;
                r_pend_valid <= 1'b1;
            end
        end else if (w_frame_end && r_pend_valid) begin
            r_act        <= r_pend;
            r_pend_valid <= 1'b0;
        end
    end

    assign w_upper_zero[NUM_DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < 2**IW; gi++) begin : g_digit
            if (gi < NUM_DIGITS) begin : g_lit
                logic [3:0] w_code;
                assign w_code           = r_act.codes[4*gi +: 4];
                assign w_upper_zero[gi] = (w_code == 4'd0) && w_upper_zero[gi+1];
                // Digit 0 always shows, so a value of zero never blanks the whole display.
                assign w_dark[gi]       = r_act.blank[gi] | (r_act.lz & w_upper_zero[gi] & (gi != 0));
                assign w_seg_tbl[gi]    = w_dark[gi] ? 8'hFF : {glyph(w_code, r_act.hex), ~r_act.dp[gi]};
            end else begin : g_pad
                assign w_seg_tbl[gi] = 8'hFF;
            end
        end
    endgenerate

    assign w_seg_sel  = w_seg_tbl[r_idx];
    assign w_digit_on = ~(NUM_DIGITS'(1) << r_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= 8'hFF;
            r_digit      <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= is_frame_end(w_state_next, w_idx_next, w_presc_next);
            if (r_state == ST_SHOW) begin
                r_seg   <= w_seg_sel;
                r_digit <= w_digit_on;
            end else begin
                r_seg   <= 8'hFF;
                r_digit <= '1;
            end
        end
    end

    assign disp.seg        = r_seg;
    assign disp.digit      = r_digit;
    assign disp.frame_done = r_frame_done;

endmodule
